// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR owner answering IRWrite/PCWrite, with a variable-latency imem handshake.
// Revision 1.0 - initial release.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        fetch_stall,
  output logic        fetch_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      addr_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // PC load is independent of the fetch FSM; a same-cycle fetch still uses the old pc_q.
    if (clk_en && PCWrite) begin
      pc_d = pc_next;
    end

    case (state_q)
      S_IDLE: begin
        if (clk_en && IRWrite) begin
          if (pc_q[1:0] == 2'b00) begin
            addr_d  = pc_q;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            instr_d = NOP;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the timeout cycle takes priority over the abort.
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          instr_d = NOP;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign fetch_stall = (state_q == S_WAIT);
  assign imem_req    = (state_q == S_WAIT);
  assign imem_addr   = addr_q;
  assign fetch_err   = err_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch responder on the far side of the multicycle controller's fetch interface. It owns the PC and instruction registers, responds to the controller's `IRWrite`/`PCWrite` strobes, and runs a request/valid handshake to instruction memory with variable latency. It exposes `opcode`/`funct` back to the controller and asserts a stall while a fetch is outstanding. Alignment or timeout failures load a NOP and flag an error.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `TIMEOUT`, 16, max WAIT cycles without `imem_valid` before abort (≥2).
- `NOP`, 32'h0000_0000, instruction loaded on reset and on any fetch error.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  qualifies `IRWrite`/`PCWrite` sampling; the memory handshake is not gated.
- `IRWrite`  in  1  fetch request from controller.
- `PCWrite`  in  1  PC load strobe from controller.
- `pc_next`  in  32  new PC value (ALU result).
- `pc`  out  32  current PC register.
- `instr`  out  32  instruction register.
- `opcode`  out  6  `instr[31:26]`, combinational.
- `funct`  out  6  `instr[5:0]`, combinational.
- `fetch_stall`  out  1  high while the FSM is in WAIT.
- `fetch_err`  out  1  sticky error flag, cleared only by `rst`.
- `imem_req`  out  1  memory read request, registered.
- `imem_addr`  out  32  registered read address, stable while `imem_req` is high.
- `imem_rdata`  in  32  read data; valid only when `imem_valid` is high.
- `imem_valid`  in  1  single-cycle read completion.

## Operation
- Reset values: `pc`=RESET_PC, `instr`=NOP, state IDLE, `imem_req`=0, `imem_addr`=0, `fetch_stall`=0, `fetch_err`=0, timeout counter=0.
- States are IDLE and WAIT. `imem_req` and `fetch_stall` are both equal to (state==WAIT).
- IDLE with `clk_en & IRWrite & pc[1:0]==0`:
  - latch `imem_addr<=pc`;
  - clear the counter;
  - go to WAIT.
- IDLE with `clk_en & IRWrite & pc[1:0]!=0`:
  - `instr<=NOP`, `fetch_err<=1`;
  - stay in IDLE; no request is issued.
- WAIT with `imem_valid`: `instr<=imem_rdata`, go to IDLE.
- WAIT without `imem_valid`:
  - if counter==TIMEOUT-1: `instr<=NOP`, `fetch_err<=1`, go to IDLE;
  - otherwise increment the counter. Width is clog2(TIMEOUT); the counter never wraps.
- `IRWrite` while in WAIT is ignored and not queued.
- `imem_valid` while in IDLE is ignored; `instr` is unchanged.
- `PCWrite & clk_en` loads `pc<=pc_next` in any state.
- `IRWrite` and `PCWrite` in the same cycle: `imem_addr` captures the old `pc`; `pc` takes `pc_next`.
- `imem_valid` on the timeout cycle: valid wins. Data is loaded and `fetch_err` is not set.
- `rst` mid-fetch: immediately returns to reset values and drops `imem_req`. A late `imem_valid` after reset is ignored.

## Timing
- `IRWrite` sampled at edge k → `imem_req`/`fetch_stall` high after edge k.
- `imem_valid` high in the cycle after edge k+n-1 → `instr` updated and `imem_req` low after edge k+n. Minimum n=1.
- Timeout: with no valid, `fetch_err`=1 and `instr`=NOP after edge k+TIMEOUT.
- Misaligned `IRWrite` at edge k → `fetch_err`=1 and `instr`=NOP after edge k; `imem_req` never rises.
- `opcode`/`funct` follow `instr` combinationally with zero cycles of latency.
- `pc` updates after the edge that samples `PCWrite & clk_en`.

## Test plan
- Reset → `pc`=0, `instr`=0, `imem_req`=0, `fetch_stall`=0, `fetch_err`=0; then `rst` high mid-WAIT → all return to reset values on assertion, without waiting for a clock edge.
- `pc`=0x40, `IRWrite`+`PCWrite` with `pc_next`=0x44, memory returns 0x012A4020 after 3 cycles:
  - `imem_addr`=0x40;
  - `fetch_stall` high for 3 cycles;
  - then `instr`=0x012A4020, `opcode`=0, `funct`=0x20, `pc`=0x44.
- Memory returns valid in the first WAIT cycle → `instr` loaded one edge after the request edge; `fetch_stall` high for exactly 1 cycle.
- No `imem_valid` → after 16 WAIT cycles `instr`=0, `fetch_err`=1, back in IDLE. Separately, valid on cycle 16 → data loaded, `fetch_err`=0.
- `pc_next`=0x42, then `IRWrite` → no `imem_req`, `fetch_err`=1, `instr`=0. `fetch_err` stays 1 across later good fetches until `rst`.
- `IRWrite` repeated during WAIT, `imem_valid` pulsed in IDLE, `clk_en`=0 with `IRWrite`/`PCWrite` high → no extra requests and no `pc`/`instr` change. An already-issued WAIT still completes with `clk_en`=0.
